// File: rtl/xgmii_pkg.sv
// Shared XGMII definitions for the transmit and receive engines.
// Holds the receive parser state encoding, the per-frame outcome encoding,
// the fixed control/header constants of the tunnel frame format, and the
// helpers that convert between the CRC register and on-wire byte order.
package xgmii_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAY,
      ST_FCS,
      ST_DROP
   } rx_state_t;

   // Result of one frame, held for the single decision cycle after W9
   typedef enum logic [2:0] {
      OUT_NONE,
      OUT_FMT,
      OUT_CRC,
      OUT_FILT,
      OUT_GOOD
   } rx_outcome_t;

   localparam logic [71:0] XGMII_START_WORD = {8'h01, 64'hd5555555555555fb};
   localparam logic [71:0] XGMII_IDLE_WORD  = {8'hff, 64'h0707070707070707};
   localparam logic [7:0]  XGMII_TERM_CHAR  = 8'hfd;
   localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL       = 8'h45;
   localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;
   localparam int          FRAME_WORDS      = 10;
   localparam logic [31:0] MAGIC_CODE       = 32'h4d414743;

   // Inverts the CRC register and mirrors the bits inside every byte,
   // giving the FCS value in the order the bytes carry it on the wire.
   function automatic logic [31:0] fcs_reverse(input logic [31:0] crc);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            r[8*b+i] = ~crc[8*b+7-i];
         end
      end
      return r;
   endfunction

   // Puts lane 0 in the top byte so MSB-first header fields read naturally
   function automatic logic [63:0] byte_swap64(input logic [63:0] d);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) begin
         r[8*k +: 8] = d[8*(7-k) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/xgmii_rx_engine_if.sv
// FIFO write-side bundle between the receive engine and the PCIe FIFO.
//   din   : 72-bit word {byte_valid[7:0], data[63:0]}
//   wr_en : write strobe
//   full  : programmable full, fewer than three free entries remain
// The engine uses the master modport, the FIFO the slave modport.
interface xgmii_rx_engine_if;
   logic [71:0] din;
   logic        wr_en;
   logic        full;

   modport master (output din, output wr_en, input full);
   modport slave  (input din, input wr_en, output full);
endinterface

// File: rtl/crc32_d64.sv
// Ethernet CRC-32 over 64 data bits per clock, MSB of data_in first.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : preset the register to all ones (start of frame)
//   enable     : fold data_in into the register this cycle
//   data_in    : 64 data bits, bit 63 processed first
//   crc_out    : current register value
module crc32_d64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        enable,
   input  logic [63:0] data_in,
   output logic [31:0] crc_out
);

   localparam logic [31:0] POLY = 32'h04c11db7;

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   // Bit-serial definition unrolled by the loop into one parallel update
   function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [63:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 63; i >= 0; i--) begin
         c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? POLY : 32'h0);
      end
      return c;
   endfunction

   always_comb begin
      crc_d = crc_q;
      if (clear) begin
         crc_d = '1;
      end else if (enable) begin
         crc_d = crc_next(crc_q, data_in);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= '1;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_out = crc_q;

endmodule

// File: rtl/xgmii_rx_engine.sv
// Receive engine for fixed 10-word IPv4/UDP tunnel frames on XGMII.
// Parses W0..W9, filters on MAC/IP/port/magic, checks the FCS, and for a
// good frame writes W7, W8 and an all-zero delimiter into the PCIe FIFO.
//   xgmii_clk, sys_rst_n     : clock, asynchronous active-low reset
//   xgmii_rxd                : {rxc[7:0], rxd[63:0]}, lane 0 first on the wire
//   fifo                     : FIFO write port (din, wr_en, full)
//   if_v4addr, if_macaddr    : local addresses to accept
//   rx_*_cnt                 : per-outcome frame counters, wrapping
module xgmii_rx_engine
   import xgmii_pkg::*;
#(
   parameter logic [15:0] UDP_PORT = 16'h0d5e,
   parameter logic [31:0] MAGIC    = MAGIC_CODE
) (
   input  logic              xgmii_clk,
   input  logic              sys_rst_n,
   input  logic [71:0]       xgmii_rxd,
   xgmii_rx_engine_if.master fifo,
   input  logic [31:0]       if_v4addr,
   input  logic [47:0]       if_macaddr,
   output logic [31:0]       rx_good_cnt,
   output logic [31:0]       rx_crc_err_cnt,
   output logic [31:0]       rx_fmt_err_cnt,
   output logic [31:0]       rx_drop_cnt
);

   localparam logic [3:0] LAST_HDR = 4'd6;
   localparam logic [3:0] LAST_PAY = 4'(FRAME_WORDS - 2);

   rx_state_t   state_q, state_d;
   rx_outcome_t pend_q, pend_d;
   logic [3:0]  idx_q, idx_d;
   logic        drop_q, drop_d;
   logic [63:0] hold0_q, hold0_d, hold1_q, hold1_d;
   logic [1:0]  commit_q, commit_d;
   logic [31:0] good_q, good_d, crcerr_q, crcerr_d, fmt_q, fmt_d, dropc_q, dropc_d;

   logic [7:0]  rxc;
   logic [63:0] rxd, rxd_sw, crc_din;
   logic        is_start, has_term, w9_ok, crc_ok, field_bad, crc_en, accept;
   logic [31:0] crc_out, fcs_calc;
   logic [71:0] din_c;
   logic        wr_en_c;

   assign rxc      = xgmii_rxd[71:64];
   assign rxd      = xgmii_rxd[63:0];
   assign rxd_sw   = byte_swap64(rxd);
   assign is_start = (xgmii_rxd == XGMII_START_WORD);
   assign w9_ok    = (rxc == 8'hf0) && (rxd[39:32] == XGMII_TERM_CHAR);
   assign crc_din  = {<<{rxd}};
   assign fcs_calc = fcs_reverse(crc_out);
   assign crc_ok   = (rxd[31:0] == {fcs_calc[7:0], fcs_calc[15:8], fcs_calc[23:16], fcs_calc[31:24]});

   crc32_d64 u_crc (
      .clk     (xgmii_clk),
      .rst_n   (sys_rst_n),
      .clear   (is_start),
      .enable  (crc_en),
      .data_in (crc_din),
      .crc_out (crc_out)
   );

   // A terminate character in any control lane ends a frame early
   always_comb begin
      has_term = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (rxc[k] && (rxd[8*k +: 8] == XGMII_TERM_CHAR)) begin
            has_term = 1'b1;
         end
      end
   end

   // Header field compare for the word currently expected in HDR
   always_comb begin
      field_bad = 1'b0;
      case (idx_q)
         4'd1:    field_bad = (rxd_sw[63:16] != if_macaddr);
         4'd2:    field_bad = (rxd_sw[31:16] != ETHERTYPE_IPV4) || (rxd_sw[15:8] != IP_VER_IHL);
         4'd3:    field_bad = (rxd_sw[7:0] != IP_PROTO_UDP);
         4'd4:    field_bad = (rxd_sw[15:0] != if_v4addr[31:16]);
         4'd5:    field_bad = (rxd_sw[63:48] != if_v4addr[15:0]) || (rxd_sw[31:16] != UDP_PORT);
         4'd6:    field_bad = (rxd_sw[47:16] != MAGIC);
         default: field_bad = 1'b0;
      endcase
   end

   // Frame parser. A filter miss only marks the frame; control characters
   // inside the body abort it. When the offending word already carries the
   // terminate there is nothing left to skip, so it returns straight to IDLE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      drop_d  = drop_q;
      pend_d  = OUT_NONE;
      hold0_d = hold0_q;
      hold1_d = hold1_q;
      crc_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_start) begin
               state_d = ST_HDR;
               idx_d   = 4'd1;
               drop_d  = 1'b0;
            end
         end
         ST_HDR, ST_PAY, ST_FCS: begin
            if (is_start) begin
               pend_d  = OUT_FMT;
               state_d = ST_HDR;
               idx_d   = 4'd1;
               drop_d  = 1'b0;
            end else if (state_q != ST_FCS) begin
               if (rxc != 8'h00) begin
                  pend_d  = OUT_FMT;
                  state_d = has_term ? ST_IDLE : ST_DROP;
               end else begin
                  crc_en = 1'b1;
                  idx_d  = idx_q + 4'd1;
                  if (state_q == ST_HDR) begin
                     drop_d = drop_q | field_bad;
                     if (idx_q == LAST_HDR) state_d = ST_PAY;
                  end else begin
                     if (idx_q == LAST_PAY) begin
                        hold1_d = rxd;
                        state_d = ST_FCS;
                     end else begin
                        hold0_d = rxd;
                     end
                  end
               end
            end else begin
               state_d = ST_IDLE;
               if (!w9_ok) begin
                  pend_d = OUT_FMT;
                  if (!has_term) state_d = ST_DROP;
               end else if (!crc_ok) begin
                  pend_d = OUT_CRC;
               end else if (drop_q) begin
                  pend_d = OUT_FILT;
               end else begin
                  pend_d = OUT_GOOD;
               end
            end
         end
         ST_DROP: begin
            if (has_term) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Decision cycle and commit sequencer. The first write depends on full
   // in the decision cycle; once started, the remaining two always follow.
   always_comb begin
      accept   = (pend_q == OUT_GOOD) && !fifo.full;
      commit_d = 2'd0;
      wr_en_c  = 1'b0;
      din_c    = '0;
      good_d   = good_q;
      crcerr_d = crcerr_q;
      fmt_d    = fmt_q;
      dropc_d  = dropc_q;
      if (commit_q == 2'd1) begin
         wr_en_c  = 1'b1;
         din_c    = {8'hff, hold1_q};
         commit_d = 2'd2;
      end else if (commit_q == 2'd2) begin
         wr_en_c  = 1'b1;
         din_c    = {8'h00, 64'h0};
      end else if (accept) begin
         wr_en_c  = 1'b1;
         din_c    = {8'hff, hold0_q};
         commit_d = 2'd1;
      end
      case (pend_q)
         OUT_FMT:  fmt_d    = fmt_q + 32'd1;
         OUT_CRC:  crcerr_d = crcerr_q + 32'd1;
         OUT_FILT: dropc_d  = dropc_q + 32'd1;
         OUT_GOOD: begin
            if (accept) good_d  = good_q + 32'd1;
            else        dropc_d = dropc_q + 32'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q  <= ST_IDLE;
         pend_q   <= OUT_NONE;
         idx_q    <= 4'd0;
         drop_q   <= 1'b0;
         hold0_q  <= '0;
         hold1_q  <= '0;
         commit_q <= 2'd0;
         good_q   <= '0;
         crcerr_q <= '0;
         fmt_q    <= '0;
         dropc_q  <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         idx_q    <= idx_d;
         drop_q   <= drop_d;
         hold0_q  <= hold0_d;
         hold1_q  <= hold1_d;
         commit_q <= commit_d;
         good_q   <= good_d;
         crcerr_q <= crcerr_d;
         fmt_q    <= fmt_d;
         dropc_q  <= dropc_d;
      end
   end

   assign fifo.din       = din_c;
   assign fifo.wr_en     = wr_en_c;
   assign rx_good_cnt    = good_q;
   assign rx_crc_err_cnt = crcerr_q;
   assign rx_fmt_err_cnt = fmt_q;
   assign rx_drop_cnt    = dropc_q;

endmodule

// File: tb/tb_xgmii_rx_engine.sv
// Self-checking bench for xgmii_rx_engine: a table of frame variants with
// expected outcomes, a FIFO scoreboard, and hand-written multi-cycle cases
// (back-to-back frames, start-word abort, reset in the middle of a commit).
module tb_xgmii_rx_engine;

   localparam logic [47:0] MY_MAC   = 48'h001122334455;
   localparam logic [31:0] MY_IP    = 32'h0a000002;
   localparam logic [15:0] MY_PORT  = 16'h0d5e;
   localparam logic [31:0] MY_MAGIC = 32'h4d414743;
   localparam logic [71:0] START_W  = {8'h01, 64'hd5555555555555fb};
   localparam logic [71:0] IDLE_W   = {8'hff, 64'h0707070707070707};

   localparam logic [1:0] O_GOOD = 2'd0;
   localparam logic [1:0] O_CRC  = 2'd1;
   localparam logic [1:0] O_FMT  = 2'd2;
   localparam logic [1:0] O_DROP = 2'd3;
   localparam int NV = 11;

   typedef struct packed {
      logic [47:0] dmac;
      logic [31:0] dip;
      logic [15:0] dport;
      logic [31:0] magic;
      logic [7:0]  fcs_xor;
      logic        trunc;
      logic        full_dec;
      logic [1:0]  outcome;
   } vec_t;

   logic        xgmii_clk = 1'b0;
   logic        sys_rst_n;
   logic [71:0] xgmii_rxd;
   logic [31:0] rx_good_cnt, rx_crc_err_cnt, rx_fmt_err_cnt, rx_drop_cnt;

   xgmii_rx_engine_if fifo_if ();

   xgmii_rx_engine #(
      .UDP_PORT (MY_PORT),
      .MAGIC    (MY_MAGIC)
   ) dut (
      .xgmii_clk      (xgmii_clk),
      .sys_rst_n      (sys_rst_n),
      .xgmii_rxd      (xgmii_rxd),
      .fifo           (fifo_if),
      .if_v4addr      (MY_IP),
      .if_macaddr     (MY_MAC),
      .rx_good_cnt    (rx_good_cnt),
      .rx_crc_err_cnt (rx_crc_err_cnt),
      .rx_fmt_err_cnt (rx_fmt_err_cnt),
      .rx_drop_cnt    (rx_drop_cnt)
   );

   always #5 xgmii_clk = ~xgmii_clk;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [71:0] exp_q[$];
   logic [31:0] exp_good = 0, exp_crc = 0, exp_fmt = 0, exp_drop = 0;
   logic [71:0] frm [10];
   logic [71:0] frm_a [10];
   vec_t        vecs [NV];

   task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] required);
      n_vec++;
      if (actual !== required) begin
         n_miss++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
      end
   endtask

   // Drives one XGMII word for one clock cycle, changing just after the edge
   task automatic applyStimulus(input logic [71:0] w);
      @(posedge xgmii_clk);
      #1 xgmii_rxd = w;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(IDLE_W);
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_good_cnt"}, 72'(rx_good_cnt), 72'(exp_good));
      checkOutput({tag, "_crc_cnt"}, 72'(rx_crc_err_cnt), 72'(exp_crc));
      checkOutput({tag, "_fmt_cnt"}, 72'(rx_fmt_err_cnt), 72'(exp_fmt));
      checkOutput({tag, "_drop_cnt"}, 72'(rx_drop_cnt), 72'(exp_drop));
      checkOutput({tag, "_pending_writes"}, 72'(exp_q.size()), 72'd0);
   endtask

   // Builds frm[0..9]; the FCS uses the reflected byte-wise Ethernet CRC
   task automatic buildFrame(input logic [47:0] dmac, input logic [31:0] dip, input logic [15:0] dport,
                             input logic [31:0] magic, input logic [63:0] p7, input logic [63:0] p8,
                             input logic [7:0] fcs_xor);
      logic [7:0]  by [64];
      logic [31:0] c;
      logic [47:0] smac;
      logic [31:0] sip;
      smac = 48'h02aabbccddee;
      sip  = 32'h0a000001;
      for (int i = 0; i < 6; i++) by[i] = dmac[47-8*i -: 8];
      for (int i = 0; i < 6; i++) by[6+i] = smac[47-8*i -: 8];
      by[12] = 8'h08; by[13] = 8'h00; by[14] = 8'h45; by[15] = 8'h00;
      by[16] = 8'h00; by[17] = 8'h2e; by[18] = 8'h12; by[19] = 8'h34;
      by[20] = 8'h40; by[21] = 8'h00; by[22] = 8'h40; by[23] = 8'h11;
      by[24] = 8'hbe; by[25] = 8'hef;
      for (int i = 0; i < 4; i++) by[26+i] = sip[31-8*i -: 8];
      for (int i = 0; i < 4; i++) by[30+i] = dip[31-8*i -: 8];
      by[34] = 8'h12; by[35] = 8'h34; by[36] = dport[15:8]; by[37] = dport[7:0];
      by[38] = 8'h00; by[39] = 8'h1a; by[40] = 8'h00; by[41] = 8'h00;
      for (int i = 0; i < 4; i++) by[42+i] = magic[31-8*i -: 8];
      by[46] = 8'h00; by[47] = 8'h00;
      for (int k = 0; k < 8; k++) begin
         by[48+k] = p7[8*k +: 8];
         by[56+k] = p8[8*k +: 8];
      end
      c = 32'hffffffff;
      for (int i = 0; i < 64; i++) begin
         c = c ^ {24'h0, by[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
      end
      c = ~c;
      frm[0] = START_W;
      for (int w = 0; w < 8; w++) begin
         frm[1+w][71:64] = 8'h00;
         for (int k = 0; k < 8; k++) frm[1+w][8*k +: 8] = by[8*w+k];
      end
      frm[9] = {8'hf0, 24'h070707, 8'hfd, c ^ {24'h0, fcs_xor}};
   endtask

   // Sends frm; trunc replaces W8 with a word ending in FD at lane 2
   task automatic sendFrame(input logic trunc, input logic full_dec);
      for (int w = 0; w < 9; w++) begin
         if (trunc && w == 8) applyStimulus({8'hfc, 40'h0707070707, 8'hfd, frm[8][15:0]});
         else                 applyStimulus(frm[w]);
      end
      if (!trunc) begin
         applyStimulus(frm[9]);
         @(posedge xgmii_clk);
         #1 xgmii_rxd = IDLE_W;
         fifo_if.full = full_dec;
         @(posedge xgmii_clk);
         #1 fifo_if.full = 1'b0;
      end
   endtask

   task automatic pushGood(input logic [63:0] p7, input logic [63:0] p8);
      exp_q.push_back({8'hff, p7});
      exp_q.push_back({8'hff, p8});
      exp_q.push_back(72'h0);
   endtask

   function automatic vec_t mkVec(input logic [47:0] dmac, input logic [31:0] dip, input logic [15:0] dport,
                                  input logic [31:0] magic, input logic [7:0] fx, input logic tr,
                                  input logic fd, input logic [1:0] oc);
      vec_t v;
      v.dmac = dmac; v.dip = dip; v.dport = dport; v.magic = magic;
      v.fcs_xor = fx; v.trunc = tr; v.full_dec = fd; v.outcome = oc;
      return v;
   endfunction

   // FIFO-side monitor: every write must match the next expected word
   always @(negedge xgmii_clk) begin
      if (fifo_if.wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL unexpected_write: got din %h, expected no write", fifo_if.din);
         end else begin
            checkOutput("fifo_din", fifo_if.din, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [63:0] p7, p8, q7, q8;
      vecs[0]  = mkVec(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, 8'h00, 1'b0, 1'b0, O_GOOD);
      vecs[1]  = mkVec(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, 8'h01, 1'b0, 1'b0, O_CRC);
      vecs[2]  = mkVec(MY_MAC, 32'h0a000003, MY_PORT, MY_MAGIC, 8'h00, 1'b0, 1'b0, O_DROP);
      vecs[3]  = mkVec(MY_MAC, MY_IP, MY_PORT, 32'h4d414744, 8'h00, 1'b0, 1'b0, O_DROP);
      vecs[4]  = mkVec(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, 8'h00, 1'b1, 1'b0, O_FMT);
      vecs[5]  = mkVec(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, 8'h00, 1'b0, 1'b0, O_GOOD);
      vecs[6]  = mkVec(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, 8'h00, 1'b0, 1'b1, O_DROP);
      vecs[7]  = mkVec(48'h001122334456, MY_IP, MY_PORT, MY_MAGIC, 8'h00, 1'b0, 1'b0, O_DROP);
      vecs[8]  = mkVec(MY_MAC, MY_IP, 16'h0d5f, MY_MAGIC, 8'h00, 1'b0, 1'b0, O_DROP);
      vecs[9]  = mkVec(MY_MAC, 32'h0a000003, MY_PORT, MY_MAGIC, 8'h10, 1'b0, 1'b0, O_CRC);
      vecs[10] = mkVec(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, 8'h00, 1'b0, 1'b0, O_GOOD);

      sys_rst_n    = 1'b0;
      xgmii_rxd    = IDLE_W;
      fifo_if.full = 1'b0;
      #12;
      checkOutput("reset_wr_en", 72'(fifo_if.wr_en), 72'd0);
      checkOutput("reset_din", fifo_if.din, 72'd0);
      checkCounters("reset");
      @(negedge xgmii_clk);
      sys_rst_n = 1'b1;
      idleCycles(2);

      for (int i = 0; i < NV; i++) begin
         if (i == 0) begin
            p7 = 64'h0706050403020100;
            p8 = 64'h0f0e0d0c0b0a0908;
         end else begin
            p7 = {$urandom, $urandom};
            p8 = {$urandom, $urandom};
         end
         buildFrame(vecs[i].dmac, vecs[i].dip, vecs[i].dport, vecs[i].magic, p7, p8, vecs[i].fcs_xor);
         case (vecs[i].outcome)
            O_GOOD: begin pushGood(p7, p8); exp_good++; end
            O_CRC:  exp_crc++;
            O_FMT:  exp_fmt++;
            default: exp_drop++;
         endcase
         sendFrame(vecs[i].trunc, vecs[i].full_dec);
         idleCycles(4);
         checkCounters($sformatf("v%0d", i));
      end

      // Two good frames separated by one idle word
      p7 = {$urandom, $urandom}; p8 = {$urandom, $urandom};
      buildFrame(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, p7, p8, 8'h00);
      frm_a = frm;
      q7 = {$urandom, $urandom}; q8 = {$urandom, $urandom};
      buildFrame(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, q7, q8, 8'h00);
      pushGood(p7, p8);
      pushGood(q7, q8);
      exp_good += 2;
      for (int w = 0; w < 10; w++) applyStimulus(frm_a[w]);
      applyStimulus(IDLE_W);
      for (int w = 0; w < 10; w++) applyStimulus(frm[w]);
      idleCycles(5);
      checkCounters("b2b");

      // Start word inside the header aborts the first frame, second is good
      for (int w = 0; w < 4; w++) applyStimulus(frm_a[w]);
      pushGood(q7, q8);
      exp_fmt++;
      exp_good++;
      sendFrame(1'b0, 1'b0);
      idleCycles(4);
      checkCounters("abort");

      // Reset asserted in cycle N+2 of a commit
      p7 = {$urandom, $urandom}; p8 = {$urandom, $urandom};
      buildFrame(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, p7, p8, 8'h00);
      exp_q.push_back({8'hff, p7});
      for (int w = 0; w < 10; w++) applyStimulus(frm[w]);
      @(posedge xgmii_clk);
      #1 xgmii_rxd = IDLE_W;
      @(negedge xgmii_clk);
      checkOutput("decision_wr_en", 72'(fifo_if.wr_en), 72'd1);
      checkOutput("decision_good_cnt_old", 72'(rx_good_cnt), 72'(exp_good));
      @(posedge xgmii_clk);
      #1;
      checkOutput("n2_good_cnt_new", 72'(rx_good_cnt), 72'(exp_good + 32'd1));
      sys_rst_n = 1'b0;
      #1;
      exp_good = 0; exp_crc = 0; exp_fmt = 0; exp_drop = 0;
      checkOutput("rst_commit_wr_en", 72'(fifo_if.wr_en), 72'd0);
      checkCounters("rst_commit");
      @(negedge xgmii_clk);
      sys_rst_n = 1'b1;
      idleCycles(5);
      checkCounters("post_rst_quiet");

      // Recovery after reset
      p7 = {$urandom, $urandom}; p8 = {$urandom, $urandom};
      buildFrame(MY_MAC, MY_IP, MY_PORT, MY_MAGIC, p7, p8, 8'h00);
      pushGood(p7, p8);
      exp_good++;
      sendFrame(1'b0, 1'b0);
      idleCycles(4);
      checkCounters("recover");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
